seg7_bcd_counter: RTL and testbench

Parametrised two-digit BCD counter that drives the 1BitSquared dual 7-segment PMOD through a time-multiplexed digit select.
- Internal prescaler generates the count tick.
- Second prescaler alternates the two digits on the shared segment bus.
- Adds up/down counting, enable, synchronous clear, programmable wrap limit, leading-zero blanking and a wrap pulse.
- Sits at top level between CLK and the PMOD pins (bits 0-6 = P1A1..P1A9 segments A-G; CA = P1A10).

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_hex_decoder.sv | 17 +
 rtl/seg7_bcd_counter.sv | 126 ++++++++++++
 tb/tb_seg7_bcd_counter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for 7-segment display blocks.
// Segment vectors are ordered {G,F,E,D,C,B,A}, active high.
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_W   = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;

  // Hex font, indexed by nibble value 0..F.
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Decimal 0..99 to packed {tens, units} BCD.
  function automatic logic [BCD_W-1:0] dec_to_bcd(input int unsigned value);
    return {4'((value / 10) % 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment decoder.
// Ports: hex   - 4-bit digit value
//        seg_c - segments {G,F,E,D,C,B,A}, active high
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] hex,
  output logic [SEG_W-1:0]   seg_c
);

  // Table lookup; dash is only a fallback value.
  always_comb begin
    seg_c = SEG_DASH;
    seg_c = HEX_SEG[hex];
  end

endmodule

// File: rtl/seg7_bcd_counter.sv
// Two-digit BCD up/down counter driving a dual 7-segment PMOD through a
// time-multiplexed digit select.
// Ports: CLK, RST_N (sync, active low), EN (count/prescaler enable),
//        DIR (1 = up), CLR (sync clear), SEG {G..A}, CA (1 = tens digit),
//        COUNT_BCD {tens, units}, WRAP (one-cycle wrap pulse).
module seg7_bcd_counter
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned MUX_HZ    = 500,
  parameter int unsigned COUNT_MAX = 99,
  parameter int unsigned BLANK_LZ  = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             DIR,
  input  logic             CLR,
  output logic [SEG_W-1:0] SEG,
  output logic             CA,
  output logic [BCD_W-1:0] COUNT_BCD,
  output logic             WRAP
);

  localparam int unsigned TDIV = CLK_HZ / TICK_HZ;
  localparam int unsigned MDIV = CLK_HZ / (2 * MUX_HZ);
  localparam int unsigned TW   = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int unsigned MW   = (MDIV > 1) ? $clog2(MDIV) : 1;

  localparam logic [TW-1:0]    T_LAST  = TW'(TDIV - 1);
  localparam logic [MW-1:0]    M_LAST  = MW'(MDIV - 1);
  localparam logic [BCD_W-1:0] MAX_BCD = dec_to_bcd(COUNT_MAX);

  // Elaboration-time parameter checks.
  if (COUNT_MAX < 1 || COUNT_MAX > 99) begin : g_bad_count_max
    $error("seg7_bcd_counter: COUNT_MAX must be 1..99");
  end
  if (TDIV < 1) begin : g_bad_tdiv
    $error("seg7_bcd_counter: CLK_HZ/TICK_HZ must be >= 1");
  end
  if (MDIV < 1) begin : g_bad_mdiv
    $error("seg7_bcd_counter: CLK_HZ/(2*MUX_HZ) must be >= 1");
  end

  logic [TW-1:0]      tick_cnt;
  logic [MW-1:0]      mux_cnt;
  logic               tick_c;
  logic               ca_nxt_c;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] units;
  logic [BCD_W-1:0]   count_nxt_c;
  logic               wrap_nxt_c;
  logic [DIGIT_W-1:0] digit_c;
  logic [SEG_W-1:0]   digit_seg_c;
  logic [SEG_W-1:0]   seg_nxt_c;

  assign tens     = COUNT_BCD[7:4];
  assign units    = COUNT_BCD[3:0];
  assign tick_c   = EN && (tick_cnt == T_LAST);
  assign ca_nxt_c = (mux_cnt == M_LAST) ? ~CA : CA;

  // BCD next-value logic; CLR wins over a coincident tick.
  always_comb begin
    count_nxt_c = COUNT_BCD;
    wrap_nxt_c  = 1'b0;
    if (CLR) begin
      count_nxt_c = '0;
    end else if (tick_c) begin
      if (DIR) begin
        if (COUNT_BCD == MAX_BCD) begin
          count_nxt_c = '0;
          wrap_nxt_c  = 1'b1;
        end else if (units == 4'd9) begin
          count_nxt_c = {tens + 4'd1, 4'd0};
        end else begin
          count_nxt_c = {tens, units + 4'd1};
        end
      end else begin
        if (COUNT_BCD == '0) begin
          count_nxt_c = MAX_BCD;
          wrap_nxt_c  = 1'b1;
        end else if (units == 4'd0) begin
          count_nxt_c = {tens - 4'd1, 4'd9};
        end else begin
          count_nxt_c = {tens, units - 4'd1};
        end
      end
    end
  end

  // Decode the digit that CA will select next cycle so SEG and CA stay paired.
  assign digit_c = ca_nxt_c ? tens : units;

  seg7_hex_decoder u_hex_decoder (
    .hex   (digit_c),
    .seg_c (digit_seg_c)
  );

  assign seg_nxt_c = ((BLANK_LZ != 0) && ca_nxt_c && (tens == 4'd0)) ? SEG_BLANK
                                                                     : digit_seg_c;

  // All state and outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tick_cnt  <= '0;
      mux_cnt   <= '0;
      COUNT_BCD <= '0;
      WRAP      <= 1'b0;
      CA        <= 1'b0;
      SEG       <= HEX_SEG[0];
    end else begin
      COUNT_BCD <= count_nxt_c;
      WRAP      <= wrap_nxt_c;
      if (CLR) begin
        tick_cnt <= '0;
      end else if (EN) begin
        tick_cnt <= tick_c ? '0 : tick_cnt + TW'(1);
      end
      mux_cnt <= (mux_cnt == M_LAST) ? '0 : mux_cnt + MW'(1);
      CA      <= ca_nxt_c;
      SEG     <= seg_nxt_c;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_counter.sv
// Self-checking bench: two counter instances (wrap 99 with blanking,
// wrap 59 without) share stimulus and are compared every cycle against a
// decimal reference model.
module tb_seg7_bcd_counter;

  localparam int unsigned CLK_HZ  = 20;
  localparam int unsigned TICK_HZ = 2;
  localparam int unsigned MUX_HZ  = 5;
  localparam int TDIV = 10;
  localparam int MDIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic       clr = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic       ca_a, ca_b;
  logic [7:0] cnt_a, cnt_b;
  logic       wrap_a, wrap_b;

  always #5 clk = ~clk;

  seg7_bcd_counter #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MUX_HZ(MUX_HZ),
    .COUNT_MAX(99), .BLANK_LZ(1)
  ) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIR(dir), .CLR(clr),
    .SEG(seg_a), .CA(ca_a), .COUNT_BCD(cnt_a), .WRAP(wrap_a)
  );

  seg7_bcd_counter #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MUX_HZ(MUX_HZ),
    .COUNT_MAX(59), .BLANK_LZ(0)
  ) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIR(dir), .CLR(clr),
    .SEG(seg_b), .CA(ca_b), .COUNT_BCD(cnt_b), .WRAP(wrap_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state: plain decimal values.
  int         m_pre;
  int         m_mux;
  bit         m_ca;
  int         m_val  [2];
  bit         m_wrap [2];
  logic [6:0] m_seg  [2];
  logic [6:0] font   [10];

  function automatic int max_of(input int i);
    return (i == 0) ? 99 : 59;
  endfunction

  function automatic bit blank_of(input int i);
    return (i == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit d, input bit c);
    bit tick;
    int old;
    if (!r) begin
      m_pre = 0;
      m_mux = 0;
      m_ca  = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_val[i]  = 0;
        m_wrap[i] = 1'b0;
        m_seg[i]  = font[0];
      end
    end else begin
      tick = e && (m_pre == TDIV - 1);
      if (m_mux == MDIV - 1) begin
        m_mux = 0;
        m_ca  = !m_ca;
      end else begin
        m_mux++;
      end
      for (int i = 0; i < 2; i++) begin
        old       = m_val[i];
        m_wrap[i] = 1'b0;
        if (c) begin
          m_val[i] = 0;
        end else if (tick) begin
          if (d) begin
            if (old == max_of(i)) begin m_val[i] = 0; m_wrap[i] = 1'b1; end
            else m_val[i] = old + 1;
          end else begin
            if (old == 0) begin m_val[i] = max_of(i); m_wrap[i] = 1'b1; end
            else m_val[i] = old - 1;
          end
        end
        // Display lags the count by one cycle.
        if (m_ca) m_seg[i] = (blank_of(i) && old / 10 == 0) ? 7'b0000000 : font[old / 10];
        else      m_seg[i] = font[old % 10];
      end
      if (c)      m_pre = 0;
      else if (e) m_pre = tick ? 0 : m_pre + 1;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit d, input bit c);
    @(negedge clk);
    rst_n = r; en = e; dir = d; clr = c;
    @(posedge clk);
    model_step(r, e, d, c);
    #1;
    cyc++;
    check("count_a", 32'(cnt_a), 32'((m_val[0] / 10) * 16 + m_val[0] % 10));
    check("count_b", 32'(cnt_b), 32'((m_val[1] / 10) * 16 + m_val[1] % 10));
    check("wrap_a",  32'(wrap_a), 32'(m_wrap[0]));
    check("wrap_b",  32'(wrap_b), 32'(m_wrap[1]));
    check("ca_a",    32'(ca_a), 32'(m_ca));
    check("ca_b",    32'(ca_b), 32'(m_ca));
    check("seg_a",   32'(seg_a), 32'(m_seg[0]));
    check("seg_b",   32'(seg_b), 32'(m_seg[1]));
  endtask

  initial begin
    font[0] = 7'b0111111; font[1] = 7'b0000110; font[2] = 7'b1011011;
    font[3] = 7'b1001111; font[4] = 7'b1100110; font[5] = 7'b1101101;
    font[6] = 7'b1111101; font[7] = 7'b0000111; font[8] = 7'b1111111;
    font[9] = 7'b1101111;

    // Reset, then a full up-count lap past the 99 -> 00 wrap.
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 1000; i++) step(1, 1, 1, 0);

    // Clear, then count down through the wrap to the limit and a units borrow.
    step(1, 1, 1, 1);
    for (int i = 0; i < 120; i++) step(1, 1, 0, 0);

    // Freeze with EN low, then resume.
    for (int i = 0; i < 35; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 1, 1, 0);

    // CLR landing exactly on a tick cycle.
    for (int i = 0; i < 2 * TDIV && m_pre != TDIV - 1; i++) step(1, 1, 1, 0);
    check("clr_tick_align", 32'(m_pre), 32'(TDIV - 1));
    step(1, 1, 1, 1);
    for (int i = 0; i < 25; i++) step(1, 1, 1, 0);

    // Randomised traffic including occasional clears and resets.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom % 150) != 0, ($urandom % 4) != 0,
           ($urandom % 3) != 0, ($urandom % 60) == 0);
    end

    // Reset with CLR high and a tick pending.
    for (int i = 0; i < 2 * TDIV && m_pre != TDIV - 1; i++) step(1, 1, 1, 0);
    check("rst_tick_align", 32'(m_pre), 32'(TDIV - 1));
    step(0, 1, 1, 1);
    check("rst_count_a", 32'(cnt_a), 32'h00);
    check("rst_seg_a",   32'(seg_a), 32'h3f);
    for (int i = 0; i < 15; i++) step(1, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
